// File: rtl/fir_polyphase_param_if.sv
// Sample, coefficient-load and result signals of the polyphase FIR, bundled so the
// filter and its neighbours share one declaration of the lane packing.
interface fir_polyphase_param_if #(
    parameter int L      = 3,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16
);
    logic                  in_valid;
    logic [L*DATA_W-1:0]   in_data;
    logic                  coef_start;
    logic                  coef_wr;
    logic [COEF_W-1:0]     coef_data;
    logic                  coef_busy;
    logic                  coef_done;
    logic                  out_valid;
    logic [L*OUT_W-1:0]    out_data;
    logic [L-1:0]          out_sat;

    modport master (
        output in_valid, in_data, coef_start, coef_wr, coef_data,
        input  coef_busy, coef_done, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, coef_start, coef_wr, coef_data,
        output coef_busy, coef_done, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/fir_polyphase_param.sv
// L-parallel direct-form polyphase FIR with double-buffered reloadable coefficients.
// Two pipeline stages: registered products, then sum + round-half-up + saturate.
module fir_polyphase_param #(
    parameter int L      = 3,
    parameter int TAPS   = 12,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_polyphase_param_if.slave bus
);
    localparam int P_W    = DATA_W + COEF_W;
    localparam int ACC_W  = P_W + $clog2(TAPS);
    localparam int WIN    = TAPS + L - 1;
    localparam int HIST_N = (TAPS > 1) ? TAPS - 1 : 1;
    localparam int IDX_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic signed [ACC_W:0] RND = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

    logic signed [DATA_W-1:0] w_lane [L];
    logic signed [DATA_W-1:0] w_win [WIN];    // index = sample age, 0 = newest lane
    logic signed [DATA_W-1:0] r_hist [HIST_N];
    logic signed [COEF_W-1:0] r_shadow [TAPS];
    logic signed [COEF_W-1:0] r_active [TAPS];
    logic signed [P_W-1:0]    r_prod [L][TAPS];
    logic                     r_v1;
    logic signed [ACC_W-1:0]  w_acc [L];
    logic signed [ACC_W:0]    w_rnd [L];
    logic signed [ACC_W:0]    w_sh [L];
    logic [L*OUT_W-1:0]       w_res;
    logic [L-1:0]             w_sat;
    logic                     r_out_valid;
    logic [L*OUT_W-1:0]       r_out_data;
    logic [L-1:0]             r_out_sat;
    logic                     r_done;
    state_t                   r_state, w_state_nxt;
    logic [IDX_W-1:0]         r_idx, w_idx_nxt;
    logic                     w_shadow_we;
    logic                     w_commit;

    // Window of the current beat's lanes followed by the stored history, ordered by age.
    for (genvar k = 0; k < L; k++) begin : g_lane
        assign w_lane[k] = bus.in_data[k*DATA_W +: DATA_W];
    end
    for (genvar i = 0; i < WIN; i++) begin : g_win
        if (i < L) begin : g_new
            assign w_win[i] = w_lane[L-1-i];
        end else begin : g_old
            assign w_win[i] = r_hist[i-L];
        end
    end

    // Delay line: advances by L samples only on accepted beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < HIST_N; i++) r_hist[i] <= '0;
        end else if (bus.in_valid) begin
            for (int unsigned i = 0; i < HIST_N; i++) r_hist[i] <= w_win[i];
        end
    end

    // Stage 1: every lane x tap product against the active bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            for (int unsigned k = 0; k < L; k++)
                for (int unsigned j = 0; j < TAPS; j++) r_prod[k][j] <= '0;
        end else begin
            r_v1 <= bus.in_valid;
            for (int unsigned k = 0; k < L; k++)
                for (int unsigned j = 0; j < TAPS; j++)
                    r_prod[k][j] <= $signed({{COEF_W{w_win[L-1-k+j][DATA_W-1]}}, w_win[L-1-k+j]})
                                  * $signed({{DATA_W{r_active[j][COEF_W-1]}}, r_active[j]});
        end
    end

    // Full-precision sum, round half up, then clamp to the output range.
    always_comb begin
        w_res = '0;
        w_sat = '0;
        for (int unsigned k = 0; k < L; k++) begin
            w_acc[k] = '0;
            for (int unsigned j = 0; j < TAPS; j++) w_acc[k] = w_acc[k] + ACC_W'(r_prod[k][j]);
            w_rnd[k] = (ACC_W+1)'(w_acc[k]) + RND;
            w_sh[k]  = w_rnd[k] >>> SHIFT;
            if ((&w_sh[k][ACC_W:OUT_W-1]) || !(|w_sh[k][ACC_W:OUT_W-1])) begin
                w_res[k*OUT_W +: OUT_W] = w_sh[k][OUT_W-1:0];
            end else begin
                w_sat[k] = 1'b1;
                w_res[k*OUT_W +: OUT_W] = w_sh[k][ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                         : {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

    // Stage 2: output registers; data holds between valid beats, sat flags do not.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= '0;
        end else begin
            r_out_valid <= r_v1;
            r_out_sat   <= r_v1 ? w_sat : '0;
            if (r_v1) r_out_data <= w_res;
        end
    end

    // Coefficient load FSM: next state and shadow/commit strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_shadow_we = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.coef_start) begin
                    w_state_nxt = S_LOAD;
                    w_idx_nxt   = '0;
                end
            end
            S_LOAD: begin
                if (bus.coef_start) begin
                    w_idx_nxt = '0;
                end else if (bus.coef_wr) begin
                    w_shadow_we = 1'b1;
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(TAPS - 1)) begin
                        w_state_nxt = S_COMMIT;
                        w_idx_nxt   = '0;
                    end
                end
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Coefficient FSM state, shadow writes and the bank swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
            for (int unsigned j = 0; j < TAPS; j++) begin
                r_shadow[j] <= '0;
                r_active[j] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_commit;
            if (w_shadow_we) r_shadow[r_idx] <= bus.coef_data;
            if (w_commit) begin
                for (int unsigned j = 0; j < TAPS; j++) r_active[j] <= r_shadow[j];
            end
        end
    end

    assign bus.coef_busy = (r_state != S_IDLE);
    assign bus.coef_done = r_done;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
endmodule

// File: tb/tb_fir_polyphase_param.sv
// Scoreboard bench for fir_polyphase_param: a reference model predicts each beat's
// outputs when it is driven, and a negedge monitor compares them when they emerge.
module tb_fir_polyphase_param;
    localparam int L = 3, TAPS = 12, DW = 16, CW = 16, OW = 16, SH = 15;

    typedef int lanes_t [L];
    typedef int bank_t [TAPS];
    typedef struct {
        logic [L*OW-1:0] d;
        logic [L-1:0]    s;
        int              cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_polyphase_param_if #(.L(L), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW)) bus ();

    fir_polyphase_param #(
        .L(L), .TAPS(TAPS), .DATA_W(DW), .COEF_W(CW), .OUT_W(OW), .SHIFT(SH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [L*OW-1:0] last_d = '0;

    longint m_hist[$];
    int m_act [TAPS];
    int m_shd [TAPS];
    int m_state;   // 0 idle, 1 load, 2 commit
    int m_idx;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < TAPS + L - 1; i++) m_hist.push_back(0);
        for (int j = 0; j < TAPS; j++) begin
            m_act[j] = 0;
            m_shd[j] = 0;
        end
        m_state = 0;
        m_idx = 0;
    endfunction

    function automatic exp_t model_beat(input lanes_t xs);
        exp_t e;
        longint acc, r;
        e.d = '0;
        e.s = '0;
        e.cyc = 0;
        for (int k = 0; k < L; k++) m_hist.push_front(longint'(xs[k]));
        for (int k = 0; k < L; k++) void'(m_hist.pop_back());
        for (int k = 0; k < L; k++) begin
            acc = 0;
            for (int j = 0; j < TAPS; j++) acc += longint'(m_act[j]) * m_hist[L-1-k+j];
            r = (acc + (longint'(1) <<< (SH - 1))) >>> SH;
            if (r > (longint'(1) <<< (OW - 1)) - 1) begin
                r = (longint'(1) <<< (OW - 1)) - 1;
                e.s[k] = 1'b1;
            end else if (r < -(longint'(1) <<< (OW - 1))) begin
                r = -(longint'(1) <<< (OW - 1));
                e.s[k] = 1'b1;
            end
            e.d[k*OW +: OW] = r[OW-1:0];
        end
        return e;
    endfunction

    // One clock cycle of stimulus; the model predicts the beat before updating its FSM.
    task automatic step(input bit v, input lanes_t xs, input bit st, input bit wr, input int cd);
        exp_t e;
        bit done_exp;
        bus.in_valid = v;
        for (int k = 0; k < L; k++) begin
            if (v) bus.in_data[k*DW +: DW] = xs[k][DW-1:0];
            else   bus.in_data[k*DW +: DW] = DW'($urandom);
        end
        bus.coef_start = st;
        bus.coef_wr = wr;
        bus.coef_data = cd[CW-1:0];
        if (v) e = model_beat(xs);
        done_exp = (m_state == 2);
        case (m_state)
            0: if (st) begin m_state = 1; m_idx = 0; end
            1: begin
                if (st) m_idx = 0;
                else if (wr) begin
                    m_shd[m_idx] = cd;
                    if (m_idx == TAPS - 1) begin m_state = 2; m_idx = 0; end
                    else m_idx++;
                end
            end
            default: begin
                for (int j = 0; j < TAPS; j++) m_act[j] = m_shd[j];
                m_state = 0;
            end
        endcase
        @(posedge clk);
        #1;
        if (v) begin
            e.cyc = cyc;
            sb.push_back(e);
        end
        chk("coef_done", 64'(bus.coef_done), 64'(done_exp));
        chk("coef_busy", 64'(bus.coef_busy), 64'(m_state != 0));
    endtask

    task automatic beat(input int a, input int b, input int c);
        lanes_t xs;
        xs = '{a, b, c};
        step(1'b1, xs, 1'b0, 1'b0, 0);
    endtask

    task automatic idle(input int n);
        lanes_t xs;
        xs = '{0, 0, 0};
        for (int i = 0; i < n; i++) step(1'b0, xs, 1'b0, 1'b0, 0);
    endtask

    task automatic load_bank(input bank_t h, input bit v, input int xv);
        lanes_t xs;
        xs = '{xv, xv, xv};
        step(v, xs, 1'b1, 1'b0, 0);
        for (int j = 0; j < TAPS; j++) step(v, xs, 1'b0, 1'b1, h[j]);
        step(v, xs, 1'b0, 1'b0, 0);
        step(v, xs, 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.coef_start = 1'b0;
        bus.coef_wr = 1'b0;
        bus.coef_data = '0;
        sb.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.coef_busy), 64'(0));
        chk("rst_done", 64'(bus.coef_done), 64'(0));
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_data", 64'(bus.out_data), 64'(0));
        chk("rst_sat", 64'(bus.out_sat), 64'(0));
        rst = 1'b0;
    endtask

    // Output monitor: a beat is due exactly one counted edge after its capture edge.
    always @(negedge clk) begin
        if (rst) begin
            last_d = '0;
        end else if (sb.size() > 0 && sb[0].cyc + 1 == cyc) begin
            mon_e = sb.pop_front();
            chk("out_valid", 64'(bus.out_valid), 64'(1));
            chk("out_data", 64'(bus.out_data), 64'(mon_e.d));
            chk("out_sat", 64'(bus.out_sat), 64'(mon_e.s));
            last_d = mon_e.d;
        end else begin
            chk("idle_valid", 64'(bus.out_valid), 64'(0));
            chk("idle_sat", 64'(bus.out_sat), 64'(0));
            chk("hold_data", 64'(bus.out_data), 64'(last_d));
        end
    end

    initial begin
        bank_t h;
        lanes_t xs;

        do_reset();

        // Impulse through a ramp bank.
        for (int j = 0; j < TAPS; j++) h[j] = 1000 * (j + 1);
        load_bank(h, 1'b0, 0);
        beat(16384, 0, 0);
        for (int i = 0; i < 5; i++) beat(0, 0, 0);
        idle(3);

        // Round-half-up around the shift boundary.
        for (int j = 0; j < TAPS; j++) h[j] = 0;
        h[0] = 1;
        load_bank(h, 1'b0, 0);
        beat(16384, 16383, -16384);
        beat(-16385, 16385, -1);
        idle(3);

        // Saturation in both directions, then back to zero.
        for (int j = 0; j < TAPS; j++) h[j] = 32767;
        load_bank(h, 1'b0, 0);
        for (int i = 0; i < 6; i++) beat(32767, 32767, 32767);
        for (int i = 0; i < 6; i++) beat(-32768, -32768, -32768);
        for (int i = 0; i < 6; i++) beat(0, 0, 0);
        idle(3);

        // Random bank, gapped stream; stray coef_wr in IDLE must be ignored.
        for (int j = 0; j < TAPS; j++) h[j] = int'($urandom_range(0, 4000)) - 2000;
        load_bank(h, 1'b0, 0);
        xs = '{0, 0, 0};
        step(1'b0, xs, 1'b0, 1'b1, 12345);
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < L; k++) xs[k] = int'($urandom_range(0, 65535)) - 32768;
            step(i % 2 == 0, xs, 1'b0, 1'b0, 0);
        end
        idle(3);

        // Reload mid-stream with a restart; start during COMMIT is ignored.
        for (int j = 0; j < TAPS; j++) h[j] = 0;
        h[0] = 16384;
        load_bank(h, 1'b1, 100);
        xs = '{100, 100, 100};
        for (int i = 0; i < 3; i++) step(1'b1, xs, 1'b0, 1'b0, 0);
        step(1'b1, xs, 1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) step(1'b1, xs, 1'b0, 1'b1, 777);
        step(1'b1, xs, 1'b1, 1'b1, 999);
        for (int j = 0; j < TAPS; j++) step(1'b1, xs, 1'b0, 1'b1, (j == 0) ? 8192 : 0);
        step(1'b1, xs, 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) step(1'b1, xs, 1'b0, 1'b0, 0);
        idle(3);

        // Reset in the middle of a load clears both banks.
        xs = '{0, 0, 0};
        step(1'b0, xs, 1'b1, 1'b0, 0);
        for (int i = 0; i < 6; i++) step(1'b1, '{300, -300, 5000}, 1'b0, 1'b1, 20000);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < L; k++) xs[k] = int'($urandom_range(0, 65535)) - 32768;
            step(1'b1, xs, 1'b0, 1'b0, 0);
        end
        idle(4);

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
